cpu_id_stage: RTL and testbench
===============================

CPU_ID_STAGE -- requirements
Module: cpu_id_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset; the clock port SHALL be named clk and the reset port SHALL be named reset.
REQ-002 The block SHALL have these ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- if_pc  in  32  IF-stage PC.
- if_insn  in  32  IF-stage instruction.
- if_en  in  1  IF-stage valid.
- stall  in  1  hold pipeline register.
- flush  in  1  squash the ID-stage output.
- gpr_rd_addr_0  out  5  GPR read address for ra (insn[25:21]).
- gpr_rd_addr_1  out  5  GPR read address for rb (insn[20:16]).
- gpr_rd_data_0  in  32  GPR read data for ra (already write-bypassed by the GPR).
- gpr_rd_data_1  in  32  GPR read data for rb (already write-bypassed by the GPR).
- ex_en, ex_gpr_we_n, ex_is_load  in  1 each  EX-stage valid, write enable (active-low), load flag.
- ex_dst_addr  in  5  EX-stage destination register.
- ex_fwd_data  in  32  EX-stage result.
- mem_en, mem_gpr_we_n  in  1 each  MEM-stage valid and write enable (active-low).
- mem_dst_addr  in  5  MEM-stage destination register.
- mem_fwd_data  in  32  MEM-stage result.
- ld_hazard  out  1  combinational stall request to IF.
- id_en  out  1  registered stage-output valid.
- id_pc, id_insn  out  32 each  registered PC and instruction.
- id_opcode  out  6  registered opcode.
- id_alu_in_0, id_alu_in_1, id_st_data  out  32 each  registered operands.
- id_dst_addr  out  5  registered destination register.
- id_gpr_we_n  out  1  registered write enable (active-low; 0 = write).
- id_is_load  out  1  registered load flag.

Function
REQ-003 The decode SHALL use opcode = insn[31:26], ra = [25:21], rb = [20:16], rc = [15:11], imm = [15:0].
REQ-004 The decode SHALL treat an instruction as I-form when opcode[0] = 1 or opcode = OP_LDW (6'h16), and as R-form otherwise.
REQ-005 The decode SHALL set alu_in_1 to imm sign-extended to 32 bits for I-form, and to the fwd(rb) value for R-form.
REQ-006 The decode SHALL set alu_in_0 to the fwd(ra) value.
REQ-007 The decode SHALL set st_data to the fwd(rb) value.
REQ-008 The decode SHALL set dst to rc for R-form and to rb for I-form.
REQ-009 The decode SHALL set gpr_we_n to 1 for OP_STW (6'h17) and to 0 otherwise.
REQ-010 The decode SHALL set is_load to 1 exactly when opcode = OP_LDW.
REQ-011 Forwarding per source register r SHALL select, in priority order:
- ex_fwd_data when ex_en & !ex_gpr_we_n & ex_dst_addr == r;
- otherwise mem_fwd_data when mem_en & !mem_gpr_we_n & mem_dst_addr == r;
- otherwise the GPR read data.
- r0 SHALL get no special treatment.
REQ-012 A source SHALL count as used as follows: ra always; rb for R-form or OP_STW.
REQ-013 ld_hazard SHALL equal if_en & ex_en & ex_is_load & !ex_gpr_we_n & (ex_dst_addr matches a used source), computed combinationally with no latency.
REQ-014 The pipeline register SHALL update on each clk edge with this priority: reset > flush > stall > ld_hazard > normal.
REQ-015 On flush, the register SHALL set id_en = 0 and id_gpr_we_n = 1, and leave all other fields don't-care; flush SHALL win over a simultaneous stall or ld_hazard.
REQ-016 On stall (without flush), the register SHALL hold every output unchanged.
REQ-017 On ld_hazard (without flush or stall), the register SHALL insert a bubble: id_en = 0, id_gpr_we_n = 1, id_is_load = 0.
REQ-018 On a normal cycle, the register SHALL capture the decoded values with one-cycle latency and set id_en = if_en.
REQ-019 When if_en = 0, the captured id_gpr_we_n SHALL be 1.
REQ-020 Branches, jumps and exceptions SHALL be out of scope for this block.

Reset
REQ-021 On reset, all registered outputs SHALL go to 0, except id_gpr_we_n, which SHALL go to 1.
REQ-022 A reset asserted mid-operation SHALL discard the instruction in flight within one cycle.

Structure
REQ-023 The shared CPU definitions file SHALL hold the opcode field positions, OP_LDW and OP_STW, the register-address width (5) and the word width (32).
REQ-024 The operand-forwarding mux SHALL be one sub-module, cpu_id_fwd, instantiated twice (once for ra, once for rb).
REQ-025 The pipeline register and the decode SHALL stay in cpu_id_stage.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- R-form: GPR r1 = 5, r2 = 7, no forwarding -> next cycle id_alu_in_0 = 5, id_alu_in_1 = 7, id_dst_addr = rc, id_en = 1.
- Forwarding priority: EX and MEM both write r3 (EX data 0xAAAA, MEM data 0xBBBB), insn reads ra = r3 -> id_alu_in_0 = 0xAAAA; with EX invalid -> 0xBBBB.
- Load-use: EX is OP_LDW writing r4, IF insn uses r4 -> ld_hazard = 1 same cycle, next cycle id_en = 0, id_gpr_we_n = 1; the I-form case with rb = r4 as destination only -> ld_hazard = 0.
- Immediate sign extension: imm = 16'h8001 -> id_alu_in_1 = 32'hFFFF8001; OP_STW -> id_gpr_we_n = 1 and id_st_data = fwd(rb).
- Stall/flush: hold for 3 cycles under stall -> outputs unchanged; stall and flush together -> id_en = 0.
- Reset mid-stream: reset for 1 cycle -> all outputs 0, id_gpr_we_n = 1; normal capture resumes on the following edge.

Source files
------------

// File: rtl/cpu_id_stage_pkg.sv
// Shared CPU definitions for the ID stage: instruction field positions, opcodes,
// widths, the ID pipeline register layout and small decode helpers.
package cpu_id_stage_pkg;

  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int OPCODE_W   = 6;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int RA_MSB     = 25;
  localparam int RA_LSB     = 21;
  localparam int RB_MSB     = 20;
  localparam int RB_LSB     = 16;
  localparam int RC_MSB     = 15;
  localparam int RC_LSB     = 11;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  typedef logic [WORD_W-1:0]     word_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [OPCODE_W-1:0]   opcode_t;

  localparam opcode_t OP_LDW = 6'h16;
  localparam opcode_t OP_STW = 6'h17;

  typedef struct packed {
    logic      en;
    word_t     pc;
    word_t     insn;
    opcode_t   opcode;
    word_t     alu_in_0;
    word_t     alu_in_1;
    word_t     st_data;
    reg_addr_t dst_addr;
    logic      gpr_we_n;
    logic      is_load;
  } id_reg_t;

  // Odd opcodes carry an immediate; LDW is the one even-coded exception.
  function automatic logic is_i_form(opcode_t op);
    return op[0] | (op == OP_LDW);
  endfunction

  function automatic word_t sext_imm(logic [IMM_MSB-IMM_LSB:0] imm);
    return {{(WORD_W-16){imm[IMM_MSB-IMM_LSB]}}, imm};
  endfunction

endpackage

// File: rtl/cpu_id_stage_if.sv
// Bundle of IF, GPR, EX/MEM forwarding and ID-output signals around the ID stage.
// The slave modport is the ID stage's view; master is the surrounding pipeline.
interface cpu_id_stage_if;
  import cpu_id_stage_pkg::*;

  word_t     if_pc;
  word_t     if_insn;
  logic      if_en;
  logic      stall;
  logic      flush;

  reg_addr_t gpr_rd_addr_0;
  reg_addr_t gpr_rd_addr_1;
  word_t     gpr_rd_data_0;
  word_t     gpr_rd_data_1;

  logic      ex_en;
  logic      ex_gpr_we_n;
  logic      ex_is_load;
  reg_addr_t ex_dst_addr;
  word_t     ex_fwd_data;

  logic      mem_en;
  logic      mem_gpr_we_n;
  reg_addr_t mem_dst_addr;
  word_t     mem_fwd_data;

  logic      ld_hazard;
  logic      id_en;
  word_t     id_pc;
  word_t     id_insn;
  opcode_t   id_opcode;
  word_t     id_alu_in_0;
  word_t     id_alu_in_1;
  word_t     id_st_data;
  reg_addr_t id_dst_addr;
  logic      id_gpr_we_n;
  logic      id_is_load;

  modport slave (
    input  if_pc, if_insn, if_en, stall, flush,
    output gpr_rd_addr_0, gpr_rd_addr_1,
    input  gpr_rd_data_0, gpr_rd_data_1,
    input  ex_en, ex_gpr_we_n, ex_is_load, ex_dst_addr, ex_fwd_data,
    input  mem_en, mem_gpr_we_n, mem_dst_addr, mem_fwd_data,
    output ld_hazard, id_en, id_pc, id_insn, id_opcode,
    output id_alu_in_0, id_alu_in_1, id_st_data, id_dst_addr, id_gpr_we_n, id_is_load
  );

  modport master (
    output if_pc, if_insn, if_en, stall, flush,
    input  gpr_rd_addr_0, gpr_rd_addr_1,
    output gpr_rd_data_0, gpr_rd_data_1,
    output ex_en, ex_gpr_we_n, ex_is_load, ex_dst_addr, ex_fwd_data,
    output mem_en, mem_gpr_we_n, mem_dst_addr, mem_fwd_data,
    input  ld_hazard, id_en, id_pc, id_insn, id_opcode,
    input  id_alu_in_0, id_alu_in_1, id_st_data, id_dst_addr, id_gpr_we_n, id_is_load
  );

endinterface

// File: rtl/cpu_id_fwd.sv
// Operand forwarding mux for one source register: EX result beats MEM result
// beats the (already write-bypassed) GPR read data.
module cpu_id_fwd
  import cpu_id_stage_pkg::*;
(
  input  reg_addr_t src_addr,
  input  word_t     gpr_data,
  input  logic      ex_en,
  input  logic      ex_gpr_we_n,
  input  reg_addr_t ex_dst_addr,
  input  word_t     ex_fwd_data,
  input  logic      mem_en,
  input  logic      mem_gpr_we_n,
  input  reg_addr_t mem_dst_addr,
  input  word_t     mem_fwd_data,
  output word_t     fwd_data
);

  // r0 is forwarded like any other register; this ISA does not hardwire it.
  always_comb begin
    fwd_data = gpr_data;
    if (ex_en && !ex_gpr_we_n && (ex_dst_addr == src_addr)) begin
      fwd_data = ex_fwd_data;
    end else if (mem_en && !mem_gpr_we_n && (mem_dst_addr == src_addr)) begin
      fwd_data = mem_fwd_data;
    end
  end

endmodule

// File: rtl/cpu_id_stage.sv
// Instruction decode stage: field decode, operand forwarding, load-use hazard
// detection and the ID/EX pipeline register.
module cpu_id_stage
  import cpu_id_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  cpu_id_stage_if.slave bus
);

  localparam id_reg_t ID_RESET = '{gpr_we_n: 1'b1, default: '0};

  opcode_t             opcode;
  reg_addr_t           ra;
  reg_addr_t           rb;
  reg_addr_t           rc;
  logic [IMM_MSB-IMM_LSB:0] imm;
  logic                i_form;
  logic                uses_rb;
  logic                ld_hazard;
  word_t               fwd_ra;
  word_t               fwd_rb;
  id_reg_t             dec;
  id_reg_t             id_d;
  id_reg_t             id_q;

  assign opcode  = bus.if_insn[OPCODE_MSB:OPCODE_LSB];
  assign ra      = bus.if_insn[RA_MSB:RA_LSB];
  assign rb      = bus.if_insn[RB_MSB:RB_LSB];
  assign rc      = bus.if_insn[RC_MSB:RC_LSB];
  assign imm     = bus.if_insn[IMM_MSB:IMM_LSB];
  assign i_form  = is_i_form(opcode);
  assign uses_rb = ~i_form | (opcode == OP_STW);

  assign bus.gpr_rd_addr_0 = ra;
  assign bus.gpr_rd_addr_1 = rb;

  cpu_id_fwd u_fwd_ra (
    .src_addr     (ra),
    .gpr_data     (bus.gpr_rd_data_0),
    .ex_en        (bus.ex_en),
    .ex_gpr_we_n  (bus.ex_gpr_we_n),
    .ex_dst_addr  (bus.ex_dst_addr),
    .ex_fwd_data  (bus.ex_fwd_data),
    .mem_en       (bus.mem_en),
    .mem_gpr_we_n (bus.mem_gpr_we_n),
    .mem_dst_addr (bus.mem_dst_addr),
    .mem_fwd_data (bus.mem_fwd_data),
    .fwd_data     (fwd_ra)
  );

  cpu_id_fwd u_fwd_rb (
    .src_addr     (rb),
    .gpr_data     (bus.gpr_rd_data_1),
    .ex_en        (bus.ex_en),
    .ex_gpr_we_n  (bus.ex_gpr_we_n),
    .ex_dst_addr  (bus.ex_dst_addr),
    .ex_fwd_data  (bus.ex_fwd_data),
    .mem_en       (bus.mem_en),
    .mem_gpr_we_n (bus.mem_gpr_we_n),
    .mem_dst_addr (bus.mem_dst_addr),
    .mem_fwd_data (bus.mem_fwd_data),
    .fwd_data     (fwd_rb)
  );

  // A load in EX cannot forward in time, so any consumer of its destination must wait.
  assign ld_hazard = bus.if_en & bus.ex_en & bus.ex_is_load & ~bus.ex_gpr_we_n &
                     ((bus.ex_dst_addr == ra) | (uses_rb & (bus.ex_dst_addr == rb)));
  assign bus.ld_hazard = ld_hazard;

  always_comb begin
    dec          = ID_RESET;
    dec.en       = bus.if_en;
    dec.pc       = bus.if_pc;
    dec.insn     = bus.if_insn;
    dec.opcode   = opcode;
    dec.alu_in_0 = fwd_ra;
    dec.alu_in_1 = i_form ? sext_imm(imm) : fwd_rb;
    dec.st_data  = fwd_rb;
    dec.dst_addr = i_form ? rb : rc;
    dec.gpr_we_n = ~bus.if_en | (opcode == OP_STW);
    dec.is_load  = (opcode == OP_LDW);
  end

  always_comb begin
    id_d = id_q;
    if (bus.flush) begin
      id_d.en       = 1'b0;
      id_d.gpr_we_n = 1'b1;
    end else if (!bus.stall) begin
      if (ld_hazard) begin
        id_d.en       = 1'b0;
        id_d.gpr_we_n = 1'b1;
        id_d.is_load  = 1'b0;
      end else begin
        id_d = dec;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_q <= ID_RESET;
    end else begin
      id_q <= id_d;
    end
  end

  assign bus.id_en       = id_q.en;
  assign bus.id_pc       = id_q.pc;
  assign bus.id_insn     = id_q.insn;
  assign bus.id_opcode   = id_q.opcode;
  assign bus.id_alu_in_0 = id_q.alu_in_0;
  assign bus.id_alu_in_1 = id_q.alu_in_1;
  assign bus.id_st_data  = id_q.st_data;
  assign bus.id_dst_addr = id_q.dst_addr;
  assign bus.id_gpr_we_n = id_q.gpr_we_n;
  assign bus.id_is_load  = id_q.is_load;

endmodule

// File: tb/tb_cpu_id_stage.sv
// Self-checking bench for cpu_id_stage: directed vector table, hand-written
// stall/flush/reset sequences, and randomized traffic against a reference model.
module tb_cpu_id_stage;
  import cpu_id_stage_pkg::*;

  typedef struct packed {
    logic      reset;
    logic      flush;
    logic      stall;
    logic      if_en;
    word_t     pc;
    word_t     insn;
    logic      ex_en;
    logic      ex_we_n;
    logic      ex_ld;
    reg_addr_t ex_dst;
    word_t     ex_data;
    logic      mem_en;
    logic      mem_we_n;
    reg_addr_t mem_dst;
    word_t     mem_data;
  } stim_t;

  typedef struct packed {
    stim_t     s;
    logic      hz;
    logic      en;
    logic      we_n;
    logic      chk_ops;
    logic      ld;
    word_t     alu0;
    word_t     alu1;
    word_t     st;
    reg_addr_t dst;
  } vec_t;

  typedef struct packed {
    logic      en;
    word_t     pc;
    word_t     insn;
    opcode_t   opcode;
    word_t     alu0;
    word_t     alu1;
    word_t     st;
    reg_addr_t dst;
    logic      we_n;
    logic      ld;
    logic      known_ops;
    logic      known_ld;
  } mdl_t;

  logic  clk = 1'b0;
  logic  reset;
  word_t gpr [32];
  int    checks = 0;
  int    passes = 0;
  mdl_t  mdl;
  vec_t  tbl [16];

  always #5 clk = ~clk;

  cpu_id_stage_if bus ();

  cpu_id_stage dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always_comb begin
    bus.gpr_rd_data_0 = gpr[bus.gpr_rd_addr_0];
    bus.gpr_rd_data_1 = gpr[bus.gpr_rd_addr_1];
  end

  function automatic word_t rform(int op, int ra, int rb, int rc);
    return word_t'((op << 26) | (ra << 21) | (rb << 16) | (rc << 11));
  endfunction

  function automatic word_t iform(int op, int ra, int rb, int imm);
    return word_t'((op << 26) | (ra << 21) | (rb << 16) | (imm & 32'hFFFF));
  endfunction

  function automatic stim_t mk(word_t pc, word_t insn);
    stim_t s = '0;
    s.if_en    = 1'b1;
    s.pc       = pc;
    s.insn     = insn;
    s.ex_we_n  = 1'b1;
    s.mem_we_n = 1'b1;
    return s;
  endfunction

  function automatic vec_t vec(stim_t s, logic hz, logic en, logic we_n, logic chk, logic ld,
                               word_t a0, word_t a1, word_t st, reg_addr_t dst);
    vec_t v;
    v.s = s; v.hz = hz; v.en = en; v.we_n = we_n; v.chk_ops = chk; v.ld = ld;
    v.alu0 = a0; v.alu1 = a1; v.st = st; v.dst = dst;
    return v;
  endfunction

  // Reference model: works from instruction arithmetic, not from the RTL's structure.
  function automatic word_t model_fwd(int r, stim_t s);
    if (s.ex_en && !s.ex_we_n && int'(s.ex_dst) == r) return s.ex_data;
    if (s.mem_en && !s.mem_we_n && int'(s.mem_dst) == r) return s.mem_data;
    return gpr[r];
  endfunction

  function automatic logic model_hazard(stim_t s);
    int  op = int'(s.insn >> 26);
    int  ra = int'((s.insn >> 21) & 32'd31);
    int  rb = int'((s.insn >> 16) & 32'd31);
    bit  imm_form = (op % 2 == 1) || (op == 22);
    bit  rb_used = !imm_form || (op == 23);
    bit  hit;
    if (!(s.if_en && s.ex_en && s.ex_ld && !s.ex_we_n)) return 1'b0;
    hit = (int'(s.ex_dst) == ra) || (rb_used && int'(s.ex_dst) == rb);
    return hit;
  endfunction

  function automatic mdl_t model_step(mdl_t m, stim_t s);
    mdl_t n = m;
    int   op, ra, rb, rc, imm;
    bit   imm_form;
    if (s.reset) begin
      n = '0;
      n.we_n = 1'b1; n.known_ops = 1'b1; n.known_ld = 1'b1;
    end else if (s.flush) begin
      n.en = 1'b0; n.we_n = 1'b1; n.known_ops = 1'b0; n.known_ld = 1'b0;
    end else if (s.stall) begin
      n = m;
    end else if (model_hazard(s)) begin
      n.en = 1'b0; n.we_n = 1'b1; n.ld = 1'b0; n.known_ops = 1'b0; n.known_ld = 1'b1;
    end else begin
      op  = int'(s.insn >> 26);
      ra  = int'((s.insn >> 21) & 32'd31);
      rb  = int'((s.insn >> 16) & 32'd31);
      rc  = int'((s.insn >> 11) & 32'd31);
      imm = int'(s.insn & 32'hFFFF);
      if (imm >= 32768) imm = imm - 65536;
      imm_form = (op % 2 == 1) || (op == 22);
      n.en     = s.if_en;
      n.pc     = s.pc;
      n.insn   = s.insn;
      n.opcode = opcode_t'(op);
      n.alu0   = model_fwd(ra, s);
      n.alu1   = imm_form ? word_t'(imm) : model_fwd(rb, s);
      n.st     = model_fwd(rb, s);
      n.dst    = reg_addr_t'(imm_form ? rb : rc);
      n.we_n   = !s.if_en || (op == 23);
      n.ld     = (op == 22);
      n.known_ops = 1'b1; n.known_ld = 1'b1;
    end
    return n;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  task automatic drive(stim_t s);
    reset            = s.reset;
    bus.flush        = s.flush;
    bus.stall        = s.stall;
    bus.if_en        = s.if_en;
    bus.if_pc        = s.pc;
    bus.if_insn      = s.insn;
    bus.ex_en        = s.ex_en;
    bus.ex_gpr_we_n  = s.ex_we_n;
    bus.ex_is_load   = s.ex_ld;
    bus.ex_dst_addr  = s.ex_dst;
    bus.ex_fwd_data  = s.ex_data;
    bus.mem_en       = s.mem_en;
    bus.mem_gpr_we_n = s.mem_we_n;
    bus.mem_dst_addr = s.mem_dst;
    bus.mem_fwd_data = s.mem_data;
  endtask

  // Drive one cycle; hazard is sampled mid-cycle, registers 1ns after the edge.
  task automatic step(stim_t s, output logic hz);
    drive(s);
    @(negedge clk);
    hz = bus.ld_hazard;
    mdl = model_step(mdl, s);
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(vec_t v, string nm);
    logic hz;
    step(v.s, hz);
    check({nm, ".ld_hazard"}, hz, v.hz);
    check({nm, ".id_en"}, bus.id_en, v.en);
    check({nm, ".id_gpr_we_n"}, bus.id_gpr_we_n, v.we_n);
    if (v.chk_ops) begin
      check({nm, ".id_pc"}, bus.id_pc, v.s.pc);
      check({nm, ".id_opcode"}, bus.id_opcode, v.s.insn >> 26);
      check({nm, ".id_alu_in_0"}, bus.id_alu_in_0, v.alu0);
      check({nm, ".id_alu_in_1"}, bus.id_alu_in_1, v.alu1);
      check({nm, ".id_st_data"}, bus.id_st_data, v.st);
      check({nm, ".id_dst_addr"}, bus.id_dst_addr, v.dst);
      check({nm, ".id_is_load"}, bus.id_is_load, v.ld);
    end
  endtask

  task automatic check_reset_state(string nm);
    check({nm, ".id_en"}, bus.id_en, 0);
    check({nm, ".id_pc"}, bus.id_pc, 0);
    check({nm, ".id_insn"}, bus.id_insn, 0);
    check({nm, ".id_opcode"}, bus.id_opcode, 0);
    check({nm, ".id_alu_in_0"}, bus.id_alu_in_0, 0);
    check({nm, ".id_alu_in_1"}, bus.id_alu_in_1, 0);
    check({nm, ".id_st_data"}, bus.id_st_data, 0);
    check({nm, ".id_dst_addr"}, bus.id_dst_addr, 0);
    check({nm, ".id_gpr_we_n"}, bus.id_gpr_we_n, 1);
    check({nm, ".id_is_load"}, bus.id_is_load, 0);
  endtask

  task automatic run_random(stim_t s);
    logic hz;
    step(s, hz);
    check("rnd.ld_hazard", hz, model_hazard(s));
    check("rnd.id_en", bus.id_en, mdl.en);
    check("rnd.id_gpr_we_n", bus.id_gpr_we_n, mdl.we_n);
    if (mdl.known_ld) check("rnd.id_is_load", bus.id_is_load, mdl.ld);
    if (mdl.known_ops) begin
      check("rnd.id_pc", bus.id_pc, mdl.pc);
      check("rnd.id_insn", bus.id_insn, mdl.insn);
      check("rnd.id_opcode", bus.id_opcode, mdl.opcode);
      check("rnd.id_alu_in_0", bus.id_alu_in_0, mdl.alu0);
      check("rnd.id_alu_in_1", bus.id_alu_in_1, mdl.alu1);
      check("rnd.id_st_data", bus.id_st_data, mdl.st);
      check("rnd.id_dst_addr", bus.id_dst_addr, mdl.dst);
    end
  endtask

  initial begin
    stim_t s;
    logic  hz;
    int    ops [6] = '{0, 1, 2, 22, 23, 5};

    for (int i = 0; i < 32; i++) gpr[i] = '0;
    gpr[1] = 32'd5; gpr[2] = 32'd7; gpr[3] = 32'h33; gpr[4] = 32'h44;
    mdl = '0;
    drive(mk(32'h0, 32'h0));
    @(posedge clk);
    #1;

    s = mk(32'h40, rform(0, 1, 2, 5));
    s.reset = 1'b1;
    step(s, hz);
    check_reset_state("reset_initial");

    s = mk(32'h100, rform(0, 1, 2, 5));
    tbl[0] = vec(s, 0, 1, 0, 1, 0, 32'd5, 32'd7, 32'd7, 5'd5);
    s = mk(32'h104, rform(0, 3, 1, 6));
    s.ex_en = 1; s.ex_we_n = 0; s.ex_dst = 3; s.ex_data = 32'hAAAA;
    s.mem_en = 1; s.mem_we_n = 0; s.mem_dst = 3; s.mem_data = 32'hBBBB;
    tbl[1] = vec(s, 0, 1, 0, 1, 0, 32'hAAAA, 32'd5, 32'd5, 5'd6);
    s.ex_en = 0;
    tbl[2] = vec(s, 0, 1, 0, 1, 0, 32'hBBBB, 32'd5, 32'd5, 5'd6);
    s.ex_en = 1; s.ex_we_n = 1;
    tbl[3] = vec(s, 0, 1, 0, 1, 0, 32'hBBBB, 32'd5, 32'd5, 5'd6);
    s.ex_en = 0; s.mem_we_n = 1;
    tbl[4] = vec(s, 0, 1, 0, 1, 0, 32'h33, 32'd5, 32'd5, 5'd6);
    s = mk(32'h114, rform(0, 4, 1, 7));
    s.ex_en = 1; s.ex_we_n = 0; s.ex_ld = 1; s.ex_dst = 4; s.ex_data = 32'hDEAD;
    tbl[5] = vec(s, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    s.insn = rform(0, 1, 4, 7);
    tbl[6] = vec(s, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    s.insn = iform(1, 1, 4, 5);
    tbl[7] = vec(s, 0, 1, 0, 1, 0, 32'd5, 32'd5, 32'hDEAD, 5'd4);
    s = mk(32'h120, iform(23, 1, 2, 16'h8001));
    tbl[8] = vec(s, 0, 1, 1, 1, 0, 32'd5, 32'hFFFF8001, 32'd7, 5'd2);
    s = mk(32'h124, iform(23, 1, 4, 0));
    s.ex_en = 1; s.ex_we_n = 0; s.ex_ld = 1; s.ex_dst = 4; s.ex_data = 32'hDEAD;
    tbl[9] = vec(s, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    s = mk(32'h128, iform(22, 2, 9, 16'h0010));
    tbl[10] = vec(s, 0, 1, 0, 1, 1, 32'd7, 32'h10, 32'd0, 5'd9);
    s = mk(32'h12C, rform(0, 4, 1, 2));
    s.if_en = 0; s.ex_en = 1; s.ex_we_n = 0; s.ex_ld = 1; s.ex_dst = 4; s.ex_data = 32'hDEAD;
    tbl[11] = vec(s, 0, 0, 1, 1, 0, 32'hDEAD, 32'd5, 32'd5, 5'd2);
    s = mk(32'h130, rform(0, 0, 0, 1));
    s.ex_en = 1; s.ex_we_n = 0; s.ex_dst = 0; s.ex_data = 32'h1234;
    tbl[12] = vec(s, 0, 1, 0, 1, 0, 32'h1234, 32'h1234, 32'h1234, 5'd1);
    s = mk(32'h134, rform(0, 2, 3, 8));
    s.ex_en = 1; s.ex_we_n = 0; s.ex_dst = 5; s.ex_data = 32'h1;
    s.mem_en = 1; s.mem_we_n = 0; s.mem_dst = 3; s.mem_data = 32'hCAFE;
    tbl[13] = vec(s, 0, 1, 0, 1, 0, 32'd7, 32'hCAFE, 32'hCAFE, 5'd8);
    s = mk(32'h138, rform(0, 1, 2, 5));
    s.flush = 1;
    tbl[14] = vec(s, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    s = mk(32'h13C, iform(3, 2, 6, 16'hFFFF));
    tbl[15] = vec(s, 0, 1, 0, 1, 0, 32'd7, 32'hFFFFFFFF, 32'd0, 5'd6);

    for (int i = 0; i < 16; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Stall holds a captured instruction for three cycles, then stall+flush squashes it.
    run_vec(vec(mk(32'h200, rform(0, 1, 2, 5)), 0, 1, 0, 1, 0, 32'd5, 32'd7, 32'd7, 5'd5), "stall_load");
    s = mk(32'h300, rform(0, 3, 4, 9));
    s.stall = 1;
    for (int i = 0; i < 3; i++) begin
      step(s, hz);
      check($sformatf("stall%0d.id_en", i), bus.id_en, 1);
      check($sformatf("stall%0d.id_pc", i), bus.id_pc, 32'h200);
      check($sformatf("stall%0d.id_alu_in_0", i), bus.id_alu_in_0, 32'd5);
      check($sformatf("stall%0d.id_alu_in_1", i), bus.id_alu_in_1, 32'd7);
      check($sformatf("stall%0d.id_dst_addr", i), bus.id_dst_addr, 5'd5);
      check($sformatf("stall%0d.id_gpr_we_n", i), bus.id_gpr_we_n, 0);
    end
    s.flush = 1;
    step(s, hz);
    check("stall_flush.id_en", bus.id_en, 0);
    check("stall_flush.id_gpr_we_n", bus.id_gpr_we_n, 1);

    // Reset in the middle of traffic discards the in-flight instruction.
    run_vec(vec(mk(32'h400, rform(0, 2, 1, 3)), 0, 1, 0, 1, 0, 32'd7, 32'd5, 32'd5, 5'd3), "pre_reset");
    s = mk(32'h404, iform(22, 1, 6, 16'h0004));
    s.reset = 1;
    step(s, hz);
    check_reset_state("reset_mid");
    run_vec(vec(mk(32'h408, rform(0, 1, 1, 4)), 0, 1, 0, 1, 0, 32'd5, 32'd5, 32'd5, 5'd4), "post_reset");

    for (int i = 0; i < 32; i++) gpr[i] = $urandom;
    for (int n = 0; n < 400; n++) begin
      s = mk($urandom, iform(ops[$urandom_range(5)], $urandom_range(7), $urandom_range(7), $urandom));
      s.reset    = ($urandom_range(49) == 0);
      s.flush    = ($urandom_range(9) == 0);
      s.stall    = ($urandom_range(5) == 0);
      s.if_en    = ($urandom_range(7) != 0);
      s.ex_en    = $urandom_range(1);
      s.ex_we_n  = ($urandom_range(3) == 0);
      s.ex_ld    = $urandom_range(1);
      s.ex_dst   = reg_addr_t'($urandom_range(7));
      s.ex_data  = $urandom;
      s.mem_en   = $urandom_range(1);
      s.mem_we_n = ($urandom_range(3) == 0);
      s.mem_dst  = reg_addr_t'($urandom_range(7));
      s.mem_data = $urandom;
      if ($urandom_range(3) == 0) s.insn = rform(0, $urandom_range(7), $urandom_range(7), $urandom_range(31));
      run_random(s);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
